// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding, funct3 access codes,
// and the funct3 legality check used at request accept.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Stores only have signed-size encodings; loads additionally accept BU/HU.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    logic bad;
    if (is_store) bad = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
    else          bad = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W) &&
                        (f3 != F3_BU) && (f3 != F3_HU);
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for one access: byte enables, replicated store data,
// right-aligned and extended load data, and the size/offset misalignment flag.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] op1,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    be        = '0;
    wdata     = '0;
    misalign  = 1'b0;
    load_data = '0;
    shifted   = mem_rdata >> {ea_lo, 3'b000};
    case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << ea_lo;
        wdata = {4{op1[7:0]}};
      end
      F3_H, F3_HU: begin
        be       = 4'b0011 << ea_lo;
        wdata    = {2{op1[15:0]}};
        misalign = ea_lo[0];
      end
      F3_W: begin
        be       = 4'b1111;
        wdata    = op1;
        misalign = |ea_lo;
      end
      default: ;
    endcase
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = shifted;
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Single-outstanding load/store sequencer between execute and a req/gnt/rvalid memory port.
// Optional REQ/WAIT bus timeout is compiled in with LSU_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | ready for a request; latches operands and effective address
//   REQ   | mem_req held with stable address/controls until mem_gnt
//   WAIT  | granted; waiting for mem_rvalid (read data or write ack)
//   RESP  | resp_valid held with stable data/flags until resp_ready
module lsu_controller
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  funct3,
   input  logic [11:0] imm,
   input  logic [31:0] op0,
   input  logic [31:0] op1,
   input  logic [4:0]  rd_in,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic [4:0]  resp_rd,
   output logic        resp_err_align,
   output logic        resp_err_bus,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        mem_err
);

   lsu_state_e  state, state_d;
   logic [31:0] ea_new, ea_q, op1_q, rdata_q;
   logic [2:0]  f3_q, la_f3;
   logic [1:0]  la_ea;
   logic [4:0]  rd_q;
   logic        is_store_q, err_align_q, err_bus_q;
   logic        accept, req_bad, tmo_hit;
   logic [3:0]  la_be;
   logic [31:0] la_wdata, la_load;
   logic        la_misalign;

   assign ea_new = op0 + {{20{imm[11]}}, imm};
   assign accept = (state == IDLE) && req_valid;

   // In IDLE the aligner judges the incoming request; afterwards it serves the latched one.
   assign la_f3 = (state == IDLE) ? funct3 : f3_q;
   assign la_ea = (state == IDLE) ? ea_new[1:0] : ea_q[1:0];

   lsu_lane_align u_align (
      .funct3    (la_f3),
      .ea_lo     (la_ea),
      .op1       (op1_q),
      .mem_rdata (mem_rdata),
      .be        (la_be),
      .wdata     (la_wdata),
      .load_data (la_load),
      .misalign  (la_misalign)
   );

   assign req_bad = f3_illegal(req_is_store, funct3) | la_misalign;

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CNT_W =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] tmo_cnt;

   // Down-counter loaded at accept; terminal count after TIMEOUT_CYCLES cycles in REQ/WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                                  tmo_cnt <= '0;
      else if (accept)                                             tmo_cnt <= TMO_LOAD;
      else if ((state == REQ || state == WAIT) && tmo_cnt != '0)   tmo_cnt <= tmo_cnt - 1'b1;
   end

   assign tmo_hit = (state == REQ || state == WAIT) && (tmo_cnt == '0);
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d    = state;
      req_ready  = 1'b0;
      mem_req    = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = req_bad ? RESP : REQ;
         end
         REQ: begin
            mem_req = 1'b1;
            if (tmo_hit)      state_d = RESP;
            else if (mem_gnt) state_d = WAIT;
         end
         WAIT: begin
            if (mem_rvalid || tmo_hit) state_d = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_store_q  <= 1'b0;
         f3_q        <= '0;
         ea_q        <= '0;
         op1_q       <= '0;
         rd_q        <= '0;
         rdata_q     <= '0;
         err_align_q <= 1'b0;
         err_bus_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               is_store_q  <= req_is_store;
               f3_q        <= funct3;
               ea_q        <= ea_new;
               op1_q       <= op1;
               rd_q        <= rd_in;
               rdata_q     <= '0;
               err_align_q <= req_bad;
               err_bus_q   <= 1'b0;
            end
            REQ: if (tmo_hit) err_bus_q <= 1'b1;
            WAIT: begin
               if (mem_rvalid) begin
                  err_bus_q <= mem_err;
                  rdata_q   <= (is_store_q || mem_err) ? '0 : la_load;
               end else if (tmo_hit) begin
                  err_bus_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_we    = mem_req & is_store_q;
   assign mem_addr  = mem_req ? {ea_q[31:2], 2'b00} : '0;
   assign mem_be    = mem_req ? la_be : '0;
   assign mem_wdata = mem_req ? la_wdata : '0;

   assign resp_rdata     = rdata_q;
   assign resp_rd        = rd_q;
   assign resp_err_align = err_align_q;
   assign resp_err_bus   = err_bus_q;

endmodule
